// File: rtl/ecc_apb_master.sv
// ecc_apb_master: APB initiator for the ECC encoder/decoder register bank.
// Takes one command at a time, programs DATA_IN, CODEWORD_WIDTH, NOISE and
// CTRL with back-to-back APB writes, waits for operation_done (bounded by a
// timeout) and hands the captured result back on a valid/ready port.
module ecc_apb_master #(
    parameter int                         AMBA_WORD       = 32,
    parameter int                         AMBA_ADDR_WIDTH = 20,
    parameter int                         DATA_WIDTH      = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL       = 'h00,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN    = 'h04,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW_WIDTH   = 'h08,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE      = 'h0C,
    parameter int                         TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_mode,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_err,
    output logic                       rsp_timeout
);

    // Counter covers 0..TIMEOUT_CYCLES-1; the last value ends the wait.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   xfer_idx_q, xfer_idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   mode_q, mode_d;
    logic [1:0]                   width_q, width_d;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic [DATA_WIDTH-1:0]        noise_q, noise_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;
    logic [AMBA_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]         pwdata_q, pwdata_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic [1:0]                   rsp_num_err_q, rsp_num_err_d;
    logic                         rsp_timeout_q, rsp_timeout_d;

    // Register address for each write slot; CTRL is last because it starts the op.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] xfer_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    xfer_addr = ADDR_DATA_IN;
            2'd1:    xfer_addr = ADDR_CW_WIDTH;
            2'd2:    xfer_addr = ADDR_NOISE;
            default: xfer_addr = ADDR_CTRL;
        endcase
    endfunction

    // Write data for each slot, resized to the APB word (zero-extend or truncate).
    function automatic logic [AMBA_WORD-1:0] xfer_wdata(
        input logic [1:0]            idx,
        input logic [1:0]            mode,
        input logic [1:0]            width,
        input logic [DATA_WIDTH-1:0] data,
        input logic [DATA_WIDTH-1:0] noise
    );
        case (idx)
            2'd0:    xfer_wdata = AMBA_WORD'(data);
            2'd1:    xfer_wdata = AMBA_WORD'(width);
            2'd2:    xfer_wdata = AMBA_WORD'(noise);
            default: xfer_wdata = AMBA_WORD'(mode);
        endcase
    endfunction

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d       = state_q;
        xfer_idx_d    = xfer_idx_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        width_d       = width_q;
        data_d        = data_q;
        noise_d       = noise_q;
        cmd_ready_d   = 1'b0;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_num_err_d = rsp_num_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    mode_d     = cmd_mode;
                    width_d    = cmd_width;
                    data_d     = cmd_data;
                    noise_d    = cmd_noise;
                    xfer_idx_d = 2'd0;
                    state_d    = ST_SETUP;
                    psel_d     = 1'b1;
                    paddr_d    = xfer_addr(2'd0);
                    pwdata_d   = xfer_wdata(2'd0, cmd_mode, cmd_width, cmd_data, cmd_noise);
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (xfer_idx_q != 2'd3) begin
                    xfer_idx_d = xfer_idx_q + 2'd1;
                    state_d    = ST_SETUP;
                    psel_d     = 1'b1;
                    paddr_d    = xfer_addr(xfer_idx_q + 2'd1);
                    pwdata_d   = xfer_wdata(xfer_idx_q + 2'd1, mode_q, width_q, data_q, noise_q);
                end else begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_DONE: begin
                // Completion takes priority over the final timeout cycle.
                if (operation_done) begin
                    rsp_data_d    = data_out;
                    rsp_num_err_d = num_of_errors;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_num_err_d = 2'd0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            xfer_idx_q    <= 2'd0;
            cnt_q         <= '0;
            mode_q        <= 2'd0;
            width_q       <= 2'd0;
            data_q        <= '0;
            noise_q       <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_num_err_q <= 2'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            xfer_idx_q    <= xfer_idx_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            width_q       <= width_d;
            data_q        <= data_d;
            noise_q       <= noise_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_num_err_q <= rsp_num_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = psel_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_num_err = rsp_num_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Bench for ecc_apb_master: table of directed commands, random commands
// checked against a reference model, and hand-written reset/protocol sequences.
module tb_ecc_apb_master;

    localparam int          TO      = 16;
    localparam logic [19:0] A_CTRL  = 20'h00;
    localparam logic [19:0] A_DIN   = 20'h04;
    localparam logic [19:0] A_CW    = 20'h08;
    localparam logic [19:0] A_NOISE = 20'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [1:0]  cmd_width;
    logic [31:0] cmd_data;
    logic [31:0] cmd_noise;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_num_err;
    logic        rsp_timeout;

    ecc_apb_master #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32),
        .ADDR_CTRL(A_CTRL), .ADDR_DATA_IN(A_DIN), .ADDR_CW_WIDTH(A_CW),
        .ADDR_NOISE(A_NOISE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_width(cmd_width), .cmd_data(cmd_data), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_num_err(rsp_num_err), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  width;
        logic [31:0] data;
        logic [31:0] noise;
        int          delay;   // cycles after CTRL ACCESS until done; 0 = never
        logic [31:0] dout;
        logic [1:0]  nerr;
        int          hold;    // response backpressure cycles
        bit          spur;    // stray done pulse during the writes
        logic [31:0] exp_data;
        logic [1:0]  exp_nerr;
        bit          exp_to;
    } vec_t;

    typedef struct {
        logic [19:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];

    // Slave-side configuration for the command in flight.
    int          done_delay = 0;
    logic [31:0] done_data  = '0;
    logic [1:0]  done_nerr  = '0;
    bit          spur_en    = 1'b0;

    vec_t vecs[7];
    vec_t v;
    int   acc;
    int   found;
    int   seen_rsp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [1:0] width,
                                input logic [31:0] data, input logic [31:0] noise,
                                input int delay, input logic [31:0] dout, input logic [1:0] nerr,
                                input int hold, input bit spur,
                                input logic [31:0] exp_data, input logic [1:0] exp_nerr,
                                input bit exp_to);
        vec_t r;
        r.mode = mode; r.width = width; r.data = data; r.noise = noise;
        r.delay = delay; r.dout = dout; r.nerr = nerr; r.hold = hold; r.spur = spur;
        r.exp_data = exp_data; r.exp_nerr = exp_nerr; r.exp_to = exp_to;
        return r;
    endfunction

    // Reference model: the result is the slave's value if done arrives within
    // the timeout window, otherwise a zeroed timeout response.
    function automatic vec_t model(input vec_t c);
        vec_t r = c;
        if (c.delay >= 1 && c.delay <= TO) begin
            r.exp_data = c.dout; r.exp_nerr = c.nerr; r.exp_to = 1'b0;
        end else begin
            r.exp_data = '0; r.exp_nerr = '0; r.exp_to = 1'b1;
        end
        return r;
    endfunction

    // APB slave: optional stray done during writes, then a done pulse some
    // cycles after the CTRL write; data_out is garbage outside the pulse.
    initial begin : slave
        operation_done = 1'b0;
        data_out       = 32'hBAD0_BAD0;
        num_of_errors  = 2'd0;
        forever begin
            @(negedge clk);
            if (PSEL && PENABLE && PADDR == A_NOISE && spur_en) begin
                @(posedge clk); #1;
                operation_done = 1'b1; data_out = ~done_data; num_of_errors = ~done_nerr;
                @(posedge clk); #1;
                operation_done = 1'b0; data_out = 32'hBAD0_BAD0; num_of_errors = 2'd0;
            end else if (PSEL && PENABLE && PADDR == A_CTRL && done_delay != 0) begin
                repeat (done_delay) @(posedge clk);
                #1;
                operation_done = 1'b1; data_out = done_data; num_of_errors = done_nerr;
                @(posedge clk); #1;
                operation_done = 1'b0; data_out = $urandom; num_of_errors = ~done_nerr;
            end
        end
    end

    // APB monitor: protocol rules and a log of completed writes.
    initial begin : apb_mon
        logic [19:0] s_addr;
        logic [31:0] s_data;
        bit          s_vld;
        s_vld = 1'b0;
        s_addr = '0;
        s_data = '0;
        forever begin
            @(negedge clk);
            if (PENABLE) check("penable_needs_psel", PSEL, 1);
            if (PSEL) check("pwrite_high", PWRITE, 1);
            if (PSEL && !PENABLE) begin
                s_addr = PADDR; s_data = PWDATA; s_vld = 1'b1;
            end else if (PSEL && PENABLE) begin
                if (s_vld) begin
                    check("paddr_stable", PADDR, s_addr);
                    check("pwdata_stable", PWDATA, s_data);
                end
                wr_q.push_back('{addr: PADDR, data: PWDATA, cyc: cyc});
                s_vld = 1'b0;
            end
        end
    end

    // Present a command and wait for acceptance; afterwards cmd_* is scrambled
    // (valid stays high) to show the latched copy is what gets written.
    task automatic send_cmd(input vec_t c, output int acc_cyc);
        @(posedge clk); #1;
        wr_q.delete();
        done_delay = c.delay; done_data = c.dout; done_nerr = c.nerr; spur_en = c.spur;
        cmd_mode = c.mode; cmd_width = c.width; cmd_data = c.data; cmd_noise = c.noise;
        cmd_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        check("cmd_accepted", (acc_cyc >= 0), 1);
        @(posedge clk); #1;
        cmd_mode = ~c.mode; cmd_width = ~c.width; cmd_data = ~c.data; cmd_noise = c.noise ^ 32'h5555_AAAA;
    endtask

    task automatic finish_cmd(input vec_t c, input int acc_cyc);
        int          rv;
        int          exp_lat;
        logic [19:0] ea[4];
        logic [31:0] ed[4];
        ea[0] = A_DIN;  ed[0] = c.data;
        ea[1] = A_CW;   ed[1] = {30'd0, c.width};
        ea[2] = A_NOISE; ed[2] = c.noise;
        ea[3] = A_CTRL; ed[3] = {30'd0, c.mode};
        exp_lat = c.exp_to ? TO + 1 : c.delay + 1;
        rv = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rv = cyc;
                break;
            end
            if (!PSEL) check("no_cmd_ready_busy", cmd_ready, 0);
        end
        check("rsp_arrived", (rv >= 0), 1);
        check("write_count", wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("wr%0d_addr", k), wr_q[k].addr, ea[k]);
                check($sformatf("wr%0d_data", k), wr_q[k].data, ed[k]);
                if (k > 0) check($sformatf("wr%0d_gap", k), wr_q[k].cyc - wr_q[k-1].cyc, 2);
            end
            check("ctrl_access_latency", wr_q[3].cyc - acc_cyc, 8);
            if (rv >= 0) check("rsp_latency", rv - wr_q[3].cyc, exp_lat);
        end
        check("rsp_data", rsp_data, c.exp_data);
        check("rsp_num_err", rsp_num_err, c.exp_nerr);
        check("rsp_timeout", rsp_timeout, c.exp_to);
        check("cmd_ready_in_resp", cmd_ready, 0);
        for (int h = 0; h < c.hold; h++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, c.exp_data);
            check("bp_rsp_to", rsp_timeout, c.exp_to);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_no_psel", PSEL, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_dropped", rsp_valid, 0);
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_width = '0; cmd_data = '0; cmd_noise = '0;
        rsp_ready = 1'b0;

        vecs[0] = mk(2'b00, 2'd0, 32'h0000_5A5A, 32'h0,         2, 32'h1234_5678, 2'd0, 0, 1'b0, 32'h1234_5678, 2'd0, 1'b0);
        vecs[1] = mk(2'b10, 2'd2, 32'hDEAD_BEEF, 32'h1,         3, 32'hDEAD_BEEF, 2'd1, 0, 1'b0, 32'hDEAD_BEEF, 2'd1, 1'b0);
        vecs[2] = mk(2'b01, 2'd1, 32'h0F0F_F0F0, 32'h8000_0001, 1, 32'h0000_CAFE, 2'd2, 5, 1'b1, 32'h0000_CAFE, 2'd2, 1'b0);
        vecs[3] = mk(2'b11, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16, 32'hA5A5_0F0F, 2'd3, 1, 1'b0, 32'hA5A5_0F0F, 2'd3, 1'b0);
        vecs[4] = mk(2'b00, 2'd1, 32'h1357_9BDF, 32'h0000_0010, 0, 32'h7777_7777, 2'd1, 0, 1'b0, 32'h0,         2'd0, 1'b1);
        vecs[5] = mk(2'b10, 2'd2, 32'h2468_ACE0, 32'h0000_0003, 17, 32'h4444_4444, 2'd2, 2, 1'b1, 32'h0,        2'd0, 1'b1);
        vecs[6] = mk(2'b01, 2'd0, 32'h0000_0001, 32'h0,         15, 32'h8000_0000, 2'd1, 0, 1'b0, 32'h8000_0000, 2'd1, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_num_err", rsp_num_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        @(posedge clk); #3;
        rst = 1'b1;

        // Directed table, applied back to back.
        for (int i = 0; i < 7; i++) begin
            send_cmd(vecs[i], acc);
            finish_cmd(vecs[i], acc);
        end

        // Reset during the NOISE write's ACCESS phase.
        v = mk(2'b10, 2'd1, 32'h1111_1111, 32'h2222_2222, 2, 32'h3333_3333, 2'd1, 0, 1'b0, 32'h3333_3333, 2'd1, 1'b0);
        send_cmd(v, acc);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (PSEL && PENABLE && PADDR == A_NOISE) begin
                found = 1;
                break;
            end
        end
        check("reached_noise_access", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_pwdata", PWDATA, 0);
        cmd_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid || PSEL) seen_rsp = 1;
        end
        check("no_rsp_after_abort", seen_rsp, 0);
        v = mk(2'b00, 2'd2, 32'hCAFE_F00D, 32'h0000_0100, 4, 32'h600D_600D, 2'd0, 0, 1'b0, 32'h600D_600D, 2'd0, 1'b0);
        send_cmd(v, acc);
        finish_cmd(v, acc);

        // Random commands against the reference model.
        for (int n = 0; n < 24; n++) begin
            v.mode  = 2'($urandom_range(0, 3));
            v.width = 2'($urandom_range(0, 3));
            v.data  = $urandom;
            v.noise = $urandom;
            v.delay = int'($urandom_range(0, 18));
            v.dout  = $urandom;
            v.nerr  = 2'($urandom_range(0, 3));
            v.hold  = int'($urandom_range(0, 3));
            v.spur  = 1'($urandom_range(0, 1));
            v = model(v);
            send_cmd(v, acc);
            finish_cmd(v, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
